// File: rtl/fir_host_driver.sv
// rtl/fir_host_driver.sv - host sequencer that programs an AXI-Lite FIR core and streams samples through it
// Optional completion polling of the core status register is enabled by FIR_DRV_DONE_POLL_EN.
module fir_host_driver #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [31:0]            data_len,
    output logic [3:0]             tap_idx,
    input  logic [31:0]            tap_coef,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            checksum,
    output logic                   tlast_err,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready
);
    typedef enum logic [2:0] {IDLE, WR_LEN, WR_TAP, WR_START, STREAM, POLL, DONE} state_t;

    localparam logic [3:0] LAST_TAP = 4'(Tape_Num - 1);

    state_t                 state;
    logic [31:0]            len;
    logic [31:0]            tx_cnt;
    logic [31:0]            rx_cnt;
    logic                   wr_active;
    logic                   wr_done;
    logic                   ss_fire;
    logic                   sm_fire;
    logic [31:0]            tx_next;
    logic [31:0]            rx_next;
    logic [pADDR_WIDTH-1:0] tap_addr;

    // A write finishes once each channel has either been accepted earlier or is accepted now.
    assign wr_done  = wr_active && (!awvalid || awready) && (!wvalid || wready);
    assign ss_fire  = ss_tvalid && ss_tready;
    assign sm_fire  = sm_tvalid && sm_tready;
    assign tx_next  = tx_cnt + {31'd0, ss_fire};
    assign rx_next  = rx_cnt + {31'd0, sm_fire};
    assign tap_addr = pADDR_WIDTH'(32'h20 + {26'd0, tap_idx, 2'b00});
    assign araddr   = '0;

`ifdef FIR_DRV_DONE_POLL_EN
    logic unused_rd;
    assign unused_rd = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};
`else
    logic unused_rd;
    assign arvalid   = 1'b0;
    assign rready    = 1'b0;
    assign unused_rd = ^{arready, rvalid, rdata};
`endif

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= IDLE;
            len       <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            wr_active <= 1'b0;
            tap_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
            tlast_err <= 1'b0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            ss_tvalid <= 1'b0;
            ss_tdata  <= '0;
            ss_tlast  <= 1'b0;
            sm_tready <= 1'b0;
`ifdef FIR_DRV_DONE_POLL_EN
            arvalid   <= 1'b0;
            rready    <= 1'b0;
`endif
        end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WR_LEN;
                        busy      <= 1'b1;
                        len       <= data_len;
                        checksum  <= '0;
                        tlast_err <= 1'b0;
                        awvalid   <= 1'b1;
                        wvalid    <= 1'b1;
                        wr_active <= 1'b1;
                        awaddr    <= pADDR_WIDTH'(12'h010);
                        wdata     <= pDATA_WIDTH'(data_len);
                    end
                end
                WR_LEN: begin
                    if (wr_done) begin
                        wr_active <= 1'b0;
                        tap_idx   <= '0;
                        state     <= WR_TAP;
                    end
                end
                WR_TAP: begin
                    // Issue one cycle after tap_idx settles so tap_coef is valid for that index.
                    if (!wr_active) begin
                        awvalid   <= 1'b1;
                        wvalid    <= 1'b1;
                        wr_active <= 1'b1;
                        awaddr    <= tap_addr;
                        wdata     <= pDATA_WIDTH'(tap_coef);
                    end else if (wr_done) begin
                        wr_active <= 1'b0;
                        if (tap_idx == LAST_TAP) begin
                            tap_idx <= '0;
                            if (len == 32'd0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= WR_START;
                                awvalid   <= 1'b1;
                                wvalid    <= 1'b1;
                                wr_active <= 1'b1;
                                awaddr    <= '0;
                                wdata     <= pDATA_WIDTH'(1);
                            end
                        end else begin
                            tap_idx <= tap_idx + 4'd1;
                        end
                    end
                end
                WR_START: begin
                    if (wr_done) begin
                        wr_active <= 1'b0;
                        state     <= STREAM;
                        tx_cnt    <= '0;
                        rx_cnt    <= '0;
                        ss_tvalid <= 1'b1;
                        ss_tdata  <= '0;
                        ss_tlast  <= (len == 32'd1);
                        sm_tready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (ss_fire) begin
                        if (tx_next == len) begin
                            ss_tvalid <= 1'b0;
                            ss_tlast  <= 1'b0;
                        end else begin
                            ss_tdata <= pDATA_WIDTH'(tx_next);
                            ss_tlast <= (tx_next == len - 32'd1);
                        end
                    end
                    if (sm_fire) begin
                        checksum <= checksum + 32'(sm_tdata);
                        if (sm_tlast != (rx_cnt == len - 32'd1)) tlast_err <= 1'b1;
                    end
                    tx_cnt <= tx_next;
                    rx_cnt <= rx_next;
                    if (tx_next == len && rx_next == len) begin
                        sm_tready <= 1'b0;
`ifdef FIR_DRV_DONE_POLL_EN
                        state     <= POLL;
                        arvalid   <= 1'b1;
`else
                        state     <= DONE;
                        done      <= 1'b1;
`endif
                    end
                end
                POLL: begin
`ifdef FIR_DRV_DONE_POLL_EN
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                    if (rready && rvalid) begin
                        rready <= 1'b0;
                        if (rdata[1]) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            arvalid <= 1'b1;
                        end
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_host_driver.sv
// tb/tb_fir_host_driver.sv - scoreboard bench for fir_host_driver with an AXI-Lite/stream FIR model
`timescale 1ns/1ps
module tb_fir_host_driver;
    localparam int TAPS = 11;

    logic        clk, rst_n, start;
    logic [31:0] data_len;
    logic [3:0]  tap_idx;
    logic [31:0] tap_coef;
    logic        busy, done, tlast_err;
    logic [31:0] checksum;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tlast, ss_tready, sm_tvalid, sm_tlast, sm_tready;
    logic [31:0] ss_tdata, sm_tdata;

    fir_host_driver #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TAPS)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .start(start), .data_len(data_len),
        .tap_idx(tap_idx), .tap_coef(tap_coef), .busy(busy), .done(done),
        .checksum(checksum), .tlast_err(tlast_err),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] coef_tbl [16];
    assign tap_coef = coef_tbl[tap_idx];

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_wr [$];
    logic [32:0] exp_ss [$];
    logic [63:0] exp_done [$];

    int wr_mode = 0, ss_mode = 0, bad_idx = -1;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_checksum(input int len);
        logic [31:0] s, y;
        s = 0;
        for (int n = 0; n < len; n++) begin
            y = 0;
            for (int k = 0; k < TAPS && k <= n; k++) y += coef_tbl[k] * 32'(n - k);
            s += y;
        end
        return s;
    endfunction

    task automatic push_expect(input int len, input bit bad);
        int reads;
        exp_wr.push_back({32'h10, 32'(len)});
        for (int k = 0; k < TAPS; k++) exp_wr.push_back({32'(32'h20 + 4 * k), coef_tbl[k]});
        if (len > 0) exp_wr.push_back({32'h0, 32'h1});
        for (int n = 0; n < len; n++) exp_ss.push_back({n == len - 1, 32'(n)});
`ifdef FIR_DRV_DONE_POLL_EN
        reads = (len > 0) ? 3 : 0;
`else
        reads = 0;
`endif
        exp_done.push_back({23'd0, bad, 8'(reads), ref_checksum(len)});
    endtask

    // FIR core model and monitor: readies are chosen at negedge, then handshakes for the next posedge are scored.
    logic        aw_got, w_got, aw_st, w_st, ss_st, sm_hold, ss_tog, r_pend;
    logic [31:0] cap_addr, cap_data, aw_prev, w_prev, mlen, rx_idx;
    logic [32:0] ss_prev;
    logic [31:0] mtaps [16];
    logic [31:0] xs [$];
    logic [31:0] yq [$];
    logic [63:0] e;
    int          rd_cnt, alone;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_got = 0; w_got = 0; aw_st = 0; w_st = 0; ss_st = 0; sm_hold = 0; ss_tog = 0;
            r_pend = 0; rd_cnt = 0; alone = 0; rx_idx = 0; mlen = 0;
            xs.delete(); yq.delete();
            awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = 0;
            ss_tready = 0; sm_tvalid = 0; sm_tdata = 0; sm_tlast = 0;
        end else begin
            if (aw_st) chk_eq("awaddr_stable", awaddr, aw_prev);
            if (w_st)  chk_eq("wdata_stable", wdata, w_prev);
            if (ss_st) chk_eq("ss_stable", {ss_tlast, ss_tdata}, ss_prev);

            case (wr_mode)
                1: begin
                    alone   = (awvalid && !wvalid) ? alone + 1 : 0;
                    wready  = 1;
                    awready = (alone >= 3);
                end
                2: begin awready = 1; wready = 1; end
                default: begin awready = 1'($urandom); wready = 1'($urandom); end
            endcase
            case (ss_mode)
                1: begin ss_tog = !ss_tog; ss_tready = ss_tog; end
                2: ss_tready = 1;
                default: ss_tready = ($urandom_range(0, 3) != 0);
            endcase

            if (awvalid && awready) begin
                chk_eq("dup_aw", aw_got, 0);
                aw_got = 1; cap_addr = 32'(awaddr);
            end
            if (wvalid && wready) begin
                chk_eq("dup_w", w_got, 0);
                w_got = 1; cap_data = wdata;
            end
            aw_st = awvalid && !awready; aw_prev = 32'(awaddr);
            w_st  = wvalid && !wready;   w_prev  = wdata;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                if (exp_wr.size() == 0) chk_eq("axil_write_extra", {cap_addr, cap_data}, 64'h0);
                else begin e = exp_wr.pop_front(); chk_eq("axil_write", {cap_addr, cap_data}, e); end
                if (cap_addr == 32'h10) mlen = cap_data;
                if (cap_addr >= 32'h20 && cap_addr < 32'h60) mtaps[(cap_addr - 32'h20) >> 2] = cap_data;
                if (cap_addr == 32'h0 && cap_data == 32'h1) begin xs.delete(); yq.delete(); rx_idx = 0; end
            end

            if (ss_tvalid && ss_tready) begin
                if (exp_ss.size() == 0) chk_eq("ss_beat_extra", {ss_tlast, ss_tdata}, 64'h0);
                else begin e = 64'(exp_ss.pop_front()); chk_eq("ss_beat", {ss_tlast, ss_tdata}, e); end
                xs.push_back(ss_tdata);
                begin
                    logic [31:0] y;
                    int n;
                    n = xs.size() - 1;
                    y = 0;
                    for (int k = 0; k < TAPS && k <= n; k++) y += mtaps[k] * xs[n - k];
                    yq.push_back(y);
                end
            end
            ss_st = ss_tvalid && !ss_tready; ss_prev = {ss_tlast, ss_tdata};

            sm_tvalid = (yq.size() > 0) && (sm_hold || $urandom_range(0, 3) != 0);
            sm_tdata  = sm_tvalid ? yq[0] : 32'h0;
            sm_tlast  = sm_tvalid && ((rx_idx == mlen - 1) || (bad_idx >= 0 && rx_idx == 32'(bad_idx)));
            if (sm_tvalid && sm_tready) begin
                void'(yq.pop_front());
                rx_idx++;
                sm_hold = 0;
            end else sm_hold = sm_tvalid;

            arready = 1'($urandom);
            rvalid  = r_pend;
            rdata   = (rd_cnt >= 2) ? 32'h6 : 32'h4;
            if (rvalid && rready) begin rd_cnt++; r_pend = 0; end
            if (arvalid && arready) begin
                chk_eq("araddr", araddr, 0);
                r_pend = 1;
            end

            if (done) begin
                if (exp_done.size() == 0) chk_eq("done_extra", done, 0);
                else begin
                    e = exp_done.pop_front();
                    chk_eq("checksum", checksum, e[31:0]);
                    chk_eq("status_reads", rd_cnt, e[39:32]);
                    chk_eq("tlast_err", tlast_err, e[40]);
                end
                rd_cnt = 0;
            end
        end
    end

    function automatic logic [63:0] out_vec();
        return {48'd0, awvalid, wvalid, arvalid, rready, ss_tvalid, sm_tready, busy, done, tlast_err,
                ss_tlast, |tap_idx, |checksum, |awaddr, |wdata, |araddr, |ss_tdata};
    endfunction

    task automatic run_one(input int len, input bit bad, input int ssm, input int wm, input bit restart);
        int cyc;
        @(negedge clk);
        for (int i = 0; i < 16; i++) coef_tbl[i] = $urandom;
        bad_idx = bad ? 1 : -1; ss_mode = ssm; wr_mode = wm;
        push_expect(len, bad);
        start = 1; data_len = 32'(len);
        @(negedge clk);
        start = 0; data_len = $urandom;
        if (restart) begin
            repeat (3) @(negedge clk);
            start = 1; data_len = 99;
            @(negedge clk);
            start = 0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin @(negedge clk); cyc++; end
        chk_eq("done_seen", done, 1);
        @(negedge clk);
        chk_eq("done_one_cycle", {done, busy}, 0);
        chk_eq("queues_drained", {exp_wr.size(), exp_ss.size(), exp_done.size()}, 0);
    endtask

    initial begin
        int cyc;
        rst_n = 0; start = 0; data_len = 0;
        for (int i = 0; i < 16; i++) coef_tbl[i] = 0;
        repeat (2) @(negedge clk);
        chk_eq("reset_outputs", out_vec(), 0);
        rst_n = 1;

        run_one(4, 0, 2, 2, 0);
        run_one(4, 0, 0, 1, 0);
        run_one(8, 0, 1, 0, 0);
        run_one(4, 1, 2, 2, 0);
        repeat (3) @(negedge clk);
        chk_eq("tlast_err_sticky", tlast_err, 1);
        run_one(1, 0, 0, 0, 0);
        run_one(0, 0, 0, 0, 0);
        run_one(5, 0, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < 16; i++) coef_tbl[i] = $urandom;
        wr_mode = 0; ss_mode = 0; bad_idx = -1;
        push_expect(4, 0);
        start = 1; data_len = 4;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while (!(busy && tap_idx == 4'd5) && cyc < 2000) begin @(negedge clk); cyc++; end
        chk_eq("reach_tap5", tap_idx, 5);
        #2 rst_n = 0;
        #1 chk_eq("reset_mid_run", out_vec(), 0);
        exp_wr.delete(); exp_ss.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk_eq("no_resume", {busy, awvalid, wvalid}, 0);
        run_one(3, 0, 0, 0, 0);

        for (int r = 0; r < 6; r++)
            run_one($urandom_range(1, 12), 0, $urandom_range(0, 2), $urandom_range(0, 2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
